// File: rtl/clk_div_pkg.sv
// -----------------------------------------------------------------------------
// clk_div_pkg
//   Shared types and constants for the run-time programmable clock divider.
//
//   Contents:
//     state_e          controller state (IDLE / RUN / STOPPING)
//     MIN_DIV          smallest legal divide ratio
//     def_div_legal()  elaboration-time range check for the reset ratio
// -----------------------------------------------------------------------------
package clk_div_pkg;

  // Encoding is fixed so the debug state output reads the same in every build.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } state_e;

  // A ratio of 0 or 1 cannot produce a clock with both a high and a low phase.
  localparam int unsigned MIN_DIV = 2;

  // True when def_div fits the phase counter and is at least MIN_DIV.
  // The upper bound is 2^cnt_w - 1 so the counter never has to reach 2^cnt_w.
  function automatic bit def_div_legal(input int unsigned def_div,
                                       input int unsigned cnt_w);
    longint max_div;
    max_div = (longint'(1) << cnt_w) - longint'(1);
    return (def_div >= MIN_DIV) && (longint'(def_div) <= max_div);
  endfunction

endpackage : clk_div_pkg

// File: rtl/clk_div_core.sv
// -----------------------------------------------------------------------------
// clk_div_core
//   Phase counter and registered divided clock.
//
//   Ports:
//     clock_in    in   sole clock, posedge
//     reset_n     in   synchronous active-low reset
//     run         in   1 = the divider is running in the coming cycle
//                      (i.e. the controller's next state is not IDLE)
//     div_active  in   ratio N currently in use (N >= 2)
//     wrap        out  current cycle is the last of the period (cnt == N-1)
//     clock_out   out  registered divided clock
//
//   While running, cnt walks 0..N-1 and clock_out is high for cnt < N/2
//   (floor), giving exactly N cycles per period. When run drops the counter
//   and output return to zero; when run rises a fresh period starts at cnt=0.
// -----------------------------------------------------------------------------
module clk_div_core #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clock_in,
  input  logic             reset_n,
  input  logic             run,
  input  logic [CNT_W-1:0] div_active,
  output logic             wrap,
  output logic             clock_out
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_q, out_d;
  // Remembers whether the previous cycle was a running one, so a start
  // (run rising) restarts the phase instead of advancing it.
  logic             run_q, run_d;
  logic [CNT_W-1:0] half;

  assign half = div_active >> 1;

  // Only meaningful while running; in IDLE cnt is 0 and N-1 >= 1.
  assign wrap = run_q && (cnt_q == (div_active - CNT_W'(1)));

  always_comb begin
    cnt_d = cnt_q;
    out_d = out_q;
    run_d = run;
    if (!run) begin
      cnt_d = '0;
      out_d = 1'b0;
    end else if (!run_q) begin
      cnt_d = '0;
      out_d = 1'b1;
    end else begin
      cnt_d = wrap ? '0 : (cnt_q + CNT_W'(1));
      // At a wrap cnt_d is 0, which is below N/2 for every legal N, so the
      // choice of old vs. new ratio at that edge does not matter.
      out_d = (cnt_d < half);
    end
  end

  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      cnt_q <= '0;
      out_q <= 1'b0;
      run_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      out_q <= out_d;
      run_q <= run_d;
    end
  end

  assign clock_out = out_q;

endmodule : clk_div_core

// File: rtl/clock_div_ctrl.sv
// -----------------------------------------------------------------------------
// clock_div_ctrl
//   Run-time controller for an integer clock divider. Ratio changes arrive on
//   a valid/ready port, wait in a one-deep holding register and are applied
//   only at a period boundary (or immediately while idle), so the output never
//   shows a runt or truncated pulse. enable starts the output on the next cycle
//   and stops it cleanly at the end of the current period.
//
//   Ports:
//     clock_in       in   sole clock, posedge
//     reset_n        in   synchronous active-low reset
//     enable         in   1 = run divided output, 0 = stop at period end
//     div_req_valid  in   new ratio request
//     div_req_ratio  in   requested ratio N
//     div_req_ready  out  holding register empty, request can be accepted
//     clock_out      out  registered divided clock
//     div_active     out  ratio currently in use
//     busy           out  not IDLE, or a request is waiting
//     err_bad_ratio  out  one-cycle pulse after accepting N < 2
//     dbg_state      out  controller state, for observation only
//
//   Handshake: a request transfers on a rising clock edge where
//   div_req_valid && div_req_ready. ready is simply "holding register empty".
//   A requester that sees ready low must keep valid and ratio stable until a
//   transfer happens. A transferred ratio below 2 is reported on
//   err_bad_ratio and dropped, leaving the holding register empty.
// -----------------------------------------------------------------------------
module clock_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned DEF_DIV = 3
) (
  input  logic             clock_in,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             div_req_valid,
  input  logic [CNT_W-1:0] div_req_ratio,
  output logic             div_req_ready,
  output logic             clock_out,
  output logic [CNT_W-1:0] div_active,
  output logic             busy,
  output logic             err_bad_ratio,
  output state_e           dbg_state
);

  if (!def_div_legal(DEF_DIV, CNT_W)) begin : g_bad_def_div
    $error("clock_div_ctrl: DEF_DIV must lie in [2, 2^CNT_W-1]");
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic             pend_valid_q, pend_valid_d;
  logic [CNT_W-1:0] pend_ratio_q, pend_ratio_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic             err_q, err_d;

  // Combinational helpers
  logic wrap;
  logic run;
  logic accept;
  logic bad_ratio;
  logic apply;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  //   RUN with enable low at a wrap goes straight to IDLE: the period that is
  //   ending is already complete, so there is nothing left to finish.
  //   STOPPING with enable high returns to RUN without touching the phase.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!enable) state_d = wrap ? ST_IDLE : ST_STOPPING;
      end
      ST_STOPPING: begin
        if (enable)    state_d = ST_RUN;
        else if (wrap) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    run           = (state_d != ST_IDLE);
    busy          = (state_q != ST_IDLE) || pend_valid_q;
    div_req_ready = !pend_valid_q;
    dbg_state     = state_q;
  end

  // ---------------------------------------------------------------------------
  // Request handshake, holding register and ratio application
  //   A ratio accepted on a wrap edge lands in the holding register on that
  //   same edge, so it cannot be applied before the following wrap. Apply and
  //   accept are mutually exclusive: one needs the register full, the other
  //   empty.
  // ---------------------------------------------------------------------------
  always_comb begin
    accept       = div_req_valid && div_req_ready;
    bad_ratio    = (div_req_ratio < CNT_W'(MIN_DIV));
    apply        = pend_valid_q && ((state_q == ST_IDLE) || wrap);

    pend_valid_d = pend_valid_q;
    pend_ratio_d = pend_ratio_q;
    div_d        = div_q;
    err_d        = accept && bad_ratio;

    if (apply) begin
      div_d        = pend_ratio_q;
      pend_valid_d = 1'b0;
    end
    if (accept && !bad_ratio) begin
      pend_valid_d = 1'b1;
      pend_ratio_d = div_req_ratio;
    end
  end

  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      pend_valid_q <= 1'b0;
      pend_ratio_q <= '0;
      div_q        <= CNT_W'(DEF_DIV);
      err_q        <= 1'b0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_ratio_q <= pend_ratio_d;
      div_q        <= div_d;
      err_q        <= err_d;
    end
  end

  assign div_active    = div_q;
  assign err_bad_ratio = err_q;

  // ---------------------------------------------------------------------------
  // Phase counter and output clock
  // ---------------------------------------------------------------------------
  clk_div_core #(
    .CNT_W (CNT_W)
  ) u_core (
    .clock_in   (clock_in),
    .reset_n    (reset_n),
    .run        (run),
    .div_active (div_q),
    .wrap       (wrap),
    .clock_out  (clock_out)
  );

endmodule : clock_div_ctrl

// File: tb/tb_clock_div_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clock_div_ctrl
//   Self-checking bench for clock_div_ctrl. A behavioural model tracks the
//   divider as (mode, phase, ratio, queue of waiting ratios); the expected
//   clock_out is derived from phase and ratio. Directed scenarios add literal
//   expectations, then a randomized phase exercises everything together.
// -----------------------------------------------------------------------------
module tb_clock_div_ctrl;
  import clk_div_pkg::*;

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned DEF_DIV = 3;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic             clock_in = 1'b0;
  logic             reset_n;
  logic             enable;
  logic             div_req_valid;
  logic [CNT_W-1:0] div_req_ratio;
  logic             div_req_ready;
  logic             clock_out;
  logic [CNT_W-1:0] div_active;
  logic             busy;
  logic             err_bad_ratio;
  state_e           dbg_state;

  always #5 clock_in = ~clock_in;

  clock_div_ctrl #(
    .CNT_W   (CNT_W),
    .DEF_DIV (DEF_DIV)
  ) dut (
    .clock_in      (clock_in),
    .reset_n       (reset_n),
    .enable        (enable),
    .div_req_valid (div_req_valid),
    .div_req_ratio (div_req_ratio),
    .div_req_ready (div_req_ready),
    .clock_out     (clock_out),
    .div_active    (div_active),
    .busy          (busy),
    .err_bad_ratio (err_bad_ratio),
    .dbg_state     (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Counters and compare helper
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Behavioural model
  //   mode: 0 idle, 1 running, 2 finishing the period before stopping.
  //   phase: position within the current period, 0..ratio-1.
  //   exp_q: ratios accepted but not yet in use (at most one).
  // ---------------------------------------------------------------------------
  int               m_mode  = 0;
  int               m_phase = 0;
  int               m_ratio = DEF_DIV;
  logic             m_err   = 1'b0;
  logic [CNT_W-1:0] exp_q[$];
  bit               chk_en  = 1'b0;

  task automatic model_step();
    bit acc, at_end, take;
    int req;
    if (!reset_n) begin
      m_mode  = 0;
      m_phase = 0;
      m_ratio = DEF_DIV;
      m_err   = 1'b0;
      exp_q.delete();
      chk_en  = 1'b1;
    end else begin
      req    = int'(div_req_ratio);
      acc    = div_req_valid && (exp_q.size() == 0);
      at_end = (m_mode != 0) && (m_phase == m_ratio - 1);
      take   = (exp_q.size() != 0) && ((m_mode == 0) || at_end);
      if (m_mode == 0) begin
        m_phase = 0;
        if (enable) m_mode = 1;
      end else begin
        m_phase = at_end ? 0 : m_phase + 1;
        if (enable)      m_mode = 1;
        else if (at_end) m_mode = 0;
        else             m_mode = 2;
      end
      if (take) m_ratio = int'(exp_q.pop_front());
      m_err = acc && (req < 2);
      if (acc && req >= 2) exp_q.push_back(div_req_ratio);
    end
  endtask

  // Scoreboard: model advances on each edge, DUT sampled 1 time unit later.
  always @(posedge clock_in) begin
    model_step();
    #1;
    if (chk_en) begin
      check("clock_out", 32'(clock_out),
            32'((m_mode != 0) && (m_phase < m_ratio / 2)));
      check("div_active", 32'(div_active), 32'(m_ratio));
      check("ready", 32'(div_req_ready), 32'(exp_q.size() == 0));
      check("busy", 32'(busy), 32'((m_mode != 0) || (exp_q.size() != 0)));
      check("err_bad_ratio", 32'(err_bad_ratio), 32'(m_err));
      check("state", 32'(dbg_state), 32'(m_mode));
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (inputs change 2 time units after the edge)
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clock_in);
    #2;
  endtask

  // Present a request and hold it until it transfers.
  task automatic send_req(input logic [CNT_W-1:0] r);
    int   waited;
    logic was_ready;
    waited        = 0;
    div_req_valid = 1'b1;
    div_req_ratio = r;
    do begin
      was_ready = div_req_ready;
      tick();
      waited++;
    end while (!was_ready && waited < 1000);
    div_req_valid = 1'b0;
    check("req_accepted", 32'(was_ready), 32'd1);
  endtask

  task automatic wait_div(input logic [CNT_W-1:0] target, input int bound);
    int n;
    n = 0;
    while (div_active != target && n < bound) begin
      tick();
      n++;
    end
    check("wait_div", 32'(div_active), 32'(target));
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [5:0] pat6;
    logic [6:0] pat7;
    logic [4:0] pat5;
    int         n, hi;

    reset_n       = 1'b0;
    enable        = 1'b0;
    div_req_valid = 1'b0;
    div_req_ratio = '0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // Reset state
    check("rst_clock_out", 32'(clock_out), 32'd0);
    check("rst_div_active", 32'(div_active), 32'd3);
    check("rst_ready", 32'(div_req_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err_bad_ratio), 32'd0);

    // 1: run at the default ratio -> 1,0,0 repeating
    enable = 1'b1;
    pat6   = '0;
    for (int i = 0; i < 6; i++) begin
      tick();
      pat6 = {pat6[4:0], clock_out};
    end
    check("t1_pattern", 32'(pat6), 32'(6'b100100));
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_div", 32'(div_active), 32'd3);

    // 2: request 4 mid-period; current period still lasts 3 cycles
    tick();                               // phase 0
    div_req_valid = 1'b1;
    div_req_ratio = 8'd4;
    tick();                               // accepted, phase 1
    div_req_valid = 1'b0;
    check("t2_ready_low", 32'(div_req_ready), 32'd0);
    check("t2_out_ph1", 32'(clock_out), 32'd0);
    pat7 = '0;
    for (int i = 0; i < 7; i++) begin
      tick();
      pat7 = {pat7[5:0], clock_out};
      if (i == 0) check("t2_ready_still_low", 32'(div_req_ready), 32'd0);
      if (i == 1) begin
        check("t2_div_new", 32'(div_active), 32'd4);
        check("t2_ready_back", 32'(div_req_ready), 32'd1);
      end
    end
    check("t2_pattern", 32'(pat7), 32'(7'b0110011));

    // 3: bad ratios 1 and 0
    div_req_valid = 1'b1;
    div_req_ratio = 8'd1;
    tick();
    div_req_valid = 1'b0;
    check("t3_err1", 32'(err_bad_ratio), 32'd1);
    check("t3_ready1", 32'(div_req_ready), 32'd1);
    check("t3_div1", 32'(div_active), 32'd4);
    tick();
    check("t3_err1_clear", 32'(err_bad_ratio), 32'd0);
    div_req_valid = 1'b1;
    div_req_ratio = 8'd0;
    tick();
    div_req_valid = 1'b0;
    check("t3_err0", 32'(err_bad_ratio), 32'd1);
    tick();
    check("t3_err0_clear", 32'(err_bad_ratio), 32'd0);
    check("t3_div0", 32'(div_active), 32'd4);

    // 4: N=5, drop enable at phase 1 -> period finishes low, then idle
    send_req(8'd5);
    wait_div(8'd5, 20);                   // now at phase 0 of an N=5 period
    tick();                               // phase 1
    check("t4_ph1_high", 32'(clock_out), 32'd1);
    enable = 1'b0;
    pat5   = '0;
    for (int i = 0; i < 5; i++) begin
      tick();
      pat5 = {pat5[3:0], clock_out};
      if (i == 2) check("t4_busy_stopping", 32'(busy), 32'd1);
      if (i == 3) begin
        check("t4_busy_idle", 32'(busy), 32'd0);
        check("t4_state_idle", 32'(dbg_state), 32'(ST_IDLE));
      end
    end
    check("t4_stop_pattern", 32'(pat5), 32'd0);
    // Re-raise enable at phase 3 instead
    enable = 1'b1;
    tick();                               // phase 0
    check("t4_restart", 32'(clock_out), 32'd1);
    tick();                               // phase 1
    enable = 1'b0;
    tick();                               // phase 2
    tick();                               // phase 3
    check("t4_state_stopping", 32'(dbg_state), 32'(ST_STOPPING));
    enable = 1'b1;
    tick();                               // phase 4
    check("t4_state_run", 32'(dbg_state), 32'(ST_RUN));
    tick();                               // phase 0, no gap
    check("t4_no_gap", 32'(clock_out), 32'd1);
    tick();                               // phase 1

    // 5: second request held while the first is waiting
    div_req_valid = 1'b1;
    div_req_ratio = 8'd2;
    tick();                               // accepted at phase 1 -> phase 2
    div_req_ratio = 8'd3;
    n = 0;
    begin
      logic was_ready;
      do begin
        was_ready = div_req_ready;
        tick();
        n++;
      end while (!was_ready && n < 50);
    end
    div_req_valid = 1'b0;
    check("t5_hold_cycles", 32'(n), 32'd4);
    check("t5_first_applied", 32'(div_active), 32'd2);
    wait_div(8'd3, 20);

    // 6: reset mid-period with a request waiting
    send_req(8'd7);
    tick();
    check("t6_pending", 32'(div_req_ready), 32'd0);
    reset_n = 1'b0;
    tick();
    check("t6_clock_out", 32'(clock_out), 32'd0);
    check("t6_div", 32'(div_active), 32'd3);
    check("t6_ready", 32'(div_req_ready), 32'd1);
    check("t6_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    tick();

    // Maximum ratio: 127 high cycles in any 255-cycle window
    send_req(8'd255);
    wait_div(8'd255, 20);
    hi = 0;
    for (int i = 0; i < 255; i++) begin
      tick();
      hi += int'(clock_out);
    end
    check("max_high_count", 32'(hi), 32'd127);
    for (int i = 0; i < 40; i++) tick();

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 15) == 0) enable = ~enable;
      if (!(div_req_valid && !div_req_ready)) begin
        div_req_valid = ($urandom_range(0, 3) == 0);
        div_req_ratio = CNT_W'($urandom_range(0, 9));
      end
      reset_n = ($urandom_range(0, 299) != 0);
      tick();
    end
    reset_n       = 1'b1;
    div_req_valid = 1'b0;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    n_fail++;
    $display("FAIL timeout: got no end of test expected finish before 200000");
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule : tb_clock_div_ctrl

// File: doc/clock_div_ctrl.md
Name: clock_div_ctrl

Overview:
- Run-time controller and generator for an integer clock divider.
- Accepts divide-ratio change requests over a valid/ready handshake.
- Applies a new ratio only at an output-period boundary, so no runt or truncated pulses appear.
- Starts and stops the divided output cleanly from an enable input; replaces fixed-ratio dividers wherever software or a sequencer must retune the ratio.

Parameters:
- CNT_W, 8: width of ratio and phase counter.
- DEF_DIV, 3: ratio loaded at reset; must satisfy 2 <= DEF_DIV <= 2^CNT_W-1.

Ports:
- clock_in  input  1  sole clock; all logic on posedge.
- reset_n  input  1  synchronous, active-low reset.
- enable  input  1  1 = run divided output, 0 = stop at next period boundary.
- div_req_valid  input  1  new ratio request.
- div_req_ratio  input  CNT_W  requested ratio N.
- div_req_ready  output  1  holding register empty, request can be accepted.
- clock_out  output  1  registered divided clock.
- div_active  output  CNT_W  ratio currently in use.
- busy  output  1  state != IDLE or a request is pending.
- err_bad_ratio  output  1  one-cycle pulse when a request with N < 2 is accepted.

Behaviour:
- Reset (reset_n==0 at posedge), required values:
  - state=IDLE, cnt=0, clock_out=0, div_active=DEF_DIV.
  - pending empty, div_req_ready=1, err_bad_ratio=0.
  - Reset mid-operation discards any pending request and the current phase.
- States and transitions:
  - IDLE: cnt=0, clock_out=0. If enable=1, next state RUN with cnt=0 and clock_out=1.
  - RUN: cnt_next = (cnt==N-1) ? 0 : cnt+1; clock_out_next = (cnt_next < N/2), using floor division.
    - Duty: N=2 gives 1 high / 1 low; N=3 gives 1 high / 2 low.
    - Period is exactly N clock_in cycles.
    - enable=0 in RUN -> STOPPING.
  - STOPPING: counting continues exactly as in RUN.
    - On wrap (cnt==N-1): go to IDLE, clock_out=0, cnt=0.
    - If enable returns to 1 before the wrap: go back to RUN with no phase disturbance.
- Request handshake:
  - Accept on valid && ready. ready = pending empty.
  - Accepted N >= 2 goes into the one-deep pending register; ready drops the next cycle.
  - Accepted N < 2 (0 or 1) raises err_bad_ratio for 1 cycle, loads nothing, and leaves ready high.
  - valid while ready=0: request is not accepted; the requester must hold it.
- Ratio application:
  - IDLE: pending ratio moves to div_active the cycle after acceptance.
  - RUN/STOPPING: pending ratio moves to div_active on the wrap edge (cnt==N-1 -> 0); the new period starts at cnt=0 with the new N. ready re-asserts the following cycle.
  - A request accepted on the same edge as a wrap is not applied at that wrap; it applies at the next wrap.
- Boundaries:
  - Maximum N = 2^CNT_W-1, so cnt never overflows.
  - Simultaneous wrap, enable=0 and pending ratio: ratio is applied and state goes to IDLE.
- Latency: enable rise to first clock_out=1 is 1 cycle; ratio request to effect is at most N+1 cycles in RUN.

Decomposition:
- Package clk_div_pkg:
  - state enumeration (IDLE, RUN, STOPPING).
  - constant MIN_DIV=2.
  - compile-time check that DEF_DIV is legal.
- Sub-module clk_div_core:
  - contents: phase counter, wrap flag and registered clock_out.
  - inputs: clock_in, reset_n, run, div_active.
- The controller (clock_div_ctrl) owns the FSM, handshake and pending register.

Test Plan:
1. Reset, then enable=1 with DEF_DIV=3 -> clock_out pattern 1,0,0 repeating, period 3, div_active=3, busy=1.
2. While running at N=3, request N=4 mid-period -> ready low until wrap; the current period completes as 3 cycles; then the pattern is 1,1,0,0 and div_active=4.
3. Request N=1, then N=0 -> err_bad_ratio pulses 1 cycle each; div_active unchanged; ready stays 1; clock_out undisturbed.
4. At N=5, drop enable at cnt=1 -> clock_out finishes the period (low through cnt=4), then stays 0; state IDLE; busy=0. Re-raising enable at cnt=3 instead -> output continues with no gap.
5. Hold a second request valid while one is pending -> it is not accepted until ready returns after the wrap; then it applies at the following wrap.
6. Assert reset_n=0 mid-period with a request pending -> next cycle clock_out=0, div_active=3, ready=1, busy=0.
